noc_test_node: RTL and testbench
================================

Name: noc_test_node

Overview:
- Traffic generator/checker endpoint attached to one local port of a NoC mesh router (2x2 mesh, node at (X_ID,Y_ID)).
- Injects a fixed number of packets toward (DEST_X_ID,DEST_Y_ID) on its sender port.
- Sinks, checks and counts packets ejected to it on its receive port.
- Used for fabric-level simulation and bring-up.

Parameters:
X_ID, 0, this node's X coordinate (4-bit field)
Y_ID, 0, this node's Y coordinate (4-bit field)
DEST_X_ID, 1, destination X of generated packets
DEST_Y_ID, 1, destination Y of generated packets
DATA_WIDTH, 32, flit width (matches Noc_Data_Width)
PKT_LEN, 3, body flits per packet (>=1)
NUM_PKTS, 8, packets to send after reset (0 = send none)
START_DELAY, 16, idle cycles after reset release before first header
GAP, 4, idle cycles between a tail handshake and the next header

Ports:
noc_clk  in  1  clock; all logic on rising edge
noc_rst  in  1  reset; one clock; reset is synchronous and active-high
receive_valid  in  1  ejected flit valid (from router)
receive_ready  out  1  node accepts ejected flit
receive_flit  in  DATA_WIDTH  ejected flit
receive_is_header  in  1  flit is packet header
receive_is_tail  in  1  flit is packet tail
sender_valid  out  1  injected flit valid (to router)
sender_ready  in  1  router accepts injected flit
sender_flit  out  DATA_WIDTH  injected flit
sender_is_header  out  1  injected flit is header
sender_is_tail  out  1  injected flit is tail
receive_num  out  8  packets received (tail handshakes)
tx_num  out  8  packets fully sent
rx_error  out  1  sticky protocol/routing error

Behaviour:
- Handshake: a transfer occurs on a cycle where valid && ready.
- While sender_valid=1 and sender_ready=0, sender_flit, sender_is_header and sender_is_tail hold stable.
- Reset values: sender_valid=0, sender_flit=0, sender_is_header=0, sender_is_tail=0, receive_ready=0, receive_num=0, tx_num=0, rx_error=0.
- Reset asserted mid-packet abandons the packet immediately; outputs return to reset values the next edge.
- Header flit layout: [31:28] dest_x, [27:24] dest_y, [23:20] src_x, [19:16] src_y, [15:8] seq, [7:0] PKT_LEN. Bits above 31 are zero when DATA_WIDTH>32.
- Body flit k (k=0..PKT_LEN-1): {src_x, src_y, seq, k[15:0]} in the low 32 bits.
- Only the last body flit has is_tail=1. The header has is_header=1, is_tail=0.
- seq starts at 0 and increments by 1 per packet, wrapping at 255.
- Sender FSM:
  - WAIT: count START_DELAY cycles, or GAP cycles after a tail.
  - HEAD: drive header; go to BODY on handshake.
  - BODY: advance k on each handshake; on the tail handshake, tx_num+1, then WAIT, or DONE once NUM_PKTS packets are sent.
  - DONE: sender_valid=0 permanently until reset.
- First header is driven START_DELAY+1 cycles after the first cycle with noc_rst=0.
- Flits within a packet are back-to-back when sender_ready=1: one flit per cycle, no bubbles.
- Receiver: receive_ready=1 every cycle after reset, unless the optional feature is enabled.
- Receiver tracks in_pkt state:
  - Header handshake sets in_pkt.
  - Tail handshake clears in_pkt and increments receive_num, saturating at 255.
  - A flit with both is_header and is_tail counts as a complete one-flit packet.
- rx_error is set (sticky until reset) on any of:
  - header while in_pkt;
  - non-header flit while not in_pkt;
  - header whose dest_x/dest_y differ from X_ID/Y_ID.
- receive_num increments even for errored packets.
- Receive and send run independently; simultaneous send and receive handshakes in one cycle are both honoured.

Optional Feature:
- Macro: NOC_TEST_NODE_BACKPRESSURE_EN.
- When defined:
  - A free-running 2-bit counter, reset to 0, increments every cycle.
  - receive_ready=0 on cycles where counter==3, otherwise 1.
  - Exercises router output stalls; receive_num totals are unchanged.
- When undefined: receive_ready=1 in every non-reset cycle.

Test Plan:
- Reset 10 cycles, release, sender_ready=1 constantly -> first header at cycle 17 after release, = {1,1,0,0,0x00,0x03}; then 3 body flits, last with is_tail; tx_num reaches 8 after 8 packets; sender_valid then stays 0.
- sender_ready toggled 0/1 randomly -> flit fields stable during stalls, no flit lost or duplicated, seq 0..7 in order.
- Loopback sender into receiver with X_ID=DEST_X_ID, Y_ID=DEST_Y_ID -> receive_num=8, rx_error=0.
- Inject header with dest (0,1) into node (1,1) -> rx_error=1 and stays 1; receive_num still increments on tail.
- Inject body flit with no preceding header, then header twice -> rx_error=1 on the first offence.
- Assert noc_rst during packet 3 body -> next cycle all outputs 0; after release, sequence restarts with seq=0, tx_num=0.

Source files
------------

// File: rtl/noc_test_node.sv
// NoC endpoint traffic generator/checker: injects NUM_PKTS packets and checks ejected ones.
// Optional receive backpressure is enabled by defining NOC_TEST_NODE_BACKPRESSURE_EN.
module noc_test_node #(
    parameter int unsigned X_ID        = 0,
    parameter int unsigned Y_ID        = 0,
    parameter int unsigned DEST_X_ID   = 1,
    parameter int unsigned DEST_Y_ID   = 1,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PKT_LEN     = 3,
    parameter int unsigned NUM_PKTS    = 8,
    parameter int unsigned START_DELAY = 16,
    parameter int unsigned GAP         = 4
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    output logic [7:0]            receive_num,
    output logic [7:0]            tx_num,
    output logic                  rx_error
);

    typedef enum logic [1:0] {StWait, StHead, StBody, StDone} tx_state_e;

    localparam logic [15:0] LastIdx = 16'(PKT_LEN - 1);
    // Counter is loaded with (idle cycles - 1) and counts down to zero.
    localparam logic [31:0] GapLoad = (GAP == 0) ? 32'd0 : 32'(GAP - 1);

    // ---------------------------------------------------------------- sender
    tx_state_e   state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] body_idx_q, body_idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [31:0] sent_q, sent_d;
    logic [7:0]  tx_num_q, tx_num_d;
    logic [31:0] flit_lo;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q    <= (NUM_PKTS == 0) ? StDone : StWait;
            wait_cnt_q <= 32'(START_DELAY);
            body_idx_q <= '0;
            seq_q      <= '0;
            sent_q     <= '0;
            tx_num_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            body_idx_q <= body_idx_d;
            seq_q      <= seq_d;
            sent_q     <= sent_d;
            tx_num_q   <= tx_num_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        wait_cnt_d       = wait_cnt_q;
        body_idx_d       = body_idx_q;
        seq_d            = seq_q;
        sent_d           = sent_q;
        tx_num_d         = tx_num_q;
        sender_valid     = 1'b0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        flit_lo          = 32'd0;

        unique case (state_q)
            StWait: begin
                if (wait_cnt_q == 32'd0) begin
                    state_d = StHead;
                end else begin
                    wait_cnt_d = wait_cnt_q - 32'd1;
                end
            end
            StHead: begin
                sender_valid     = 1'b1;
                sender_is_header = 1'b1;
                flit_lo = {4'(DEST_X_ID), 4'(DEST_Y_ID), 4'(X_ID), 4'(Y_ID), seq_q, 8'(PKT_LEN)};
                if (sender_ready) begin
                    state_d    = StBody;
                    body_idx_d = '0;
                end
            end
            StBody: begin
                sender_valid   = 1'b1;
                sender_is_tail = (body_idx_q == LastIdx);
                flit_lo        = {4'(X_ID), 4'(Y_ID), seq_q, body_idx_q};
                if (sender_ready) begin
                    if (body_idx_q == LastIdx) begin
                        seq_d    = seq_q + 8'd1;
                        sent_d   = sent_q + 32'd1;
                        tx_num_d = (tx_num_q == 8'hff) ? tx_num_q : tx_num_q + 8'd1;
                        if (sent_q + 32'd1 >= 32'(NUM_PKTS)) begin
                            state_d = StDone;
                        end else if (GAP == 0) begin
                            state_d = StHead;
                        end else begin
                            state_d    = StWait;
                            wait_cnt_d = GapLoad;
                        end
                    end else begin
                        body_idx_d = body_idx_q + 16'd1;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StDone;
            end
        endcase
    end

    // Header/body layouts occupy the low 32 bits; wider flits are zero-extended.
    assign sender_flit = DATA_WIDTH'(flit_lo);
    assign tx_num      = tx_num_q;

    // -------------------------------------------------------------- receiver
    logic       rx_ready_q;
    logic       in_pkt_q, in_pkt_d;
    logic [7:0] rx_num_q, rx_num_d;
    logic       rx_err_q, rx_err_d;
    logic       rx_hs;
    logic       dest_ok;
    logic       unused_flit_bits;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            rx_ready_q <= 1'b0;
            in_pkt_q   <= 1'b0;
            rx_num_q   <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_ready_q <= 1'b1;
            in_pkt_q   <= in_pkt_d;
            rx_num_q   <= rx_num_d;
            rx_err_q   <= rx_err_d;
        end
    end

`ifdef NOC_TEST_NODE_BACKPRESSURE_EN
    logic [1:0] bp_cnt_q;

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            bp_cnt_q <= 2'd0;
        end else begin
            bp_cnt_q <= bp_cnt_q + 2'd1;
        end
    end

    // Stall one cycle in four to exercise router output backpressure.
    assign receive_ready = rx_ready_q && (bp_cnt_q != 2'd3);
`else
    assign receive_ready = rx_ready_q;
`endif

    assign rx_hs   = receive_valid && receive_ready;
    assign dest_ok = (receive_flit[31:28] == 4'(X_ID)) && (receive_flit[27:24] == 4'(Y_ID));
    assign unused_flit_bits = ^receive_flit;

    always_comb begin
        in_pkt_d = in_pkt_q;
        rx_num_d = rx_num_q;
        rx_err_d = rx_err_q;
        if (rx_hs) begin
            if (receive_is_header) begin
                if (in_pkt_q || !dest_ok) begin
                    rx_err_d = 1'b1;
                end
                in_pkt_d = !receive_is_tail;
            end else begin
                if (!in_pkt_q) begin
                    rx_err_d = 1'b1;
                end
                if (receive_is_tail) begin
                    in_pkt_d = 1'b0;
                end
            end
            if (receive_is_tail && (rx_num_q != 8'hff)) begin
                rx_num_d = rx_num_q + 8'd1;
            end
        end
    end

    assign receive_num = rx_num_q;
    assign rx_error    = rx_err_q;

endmodule

// File: tb/tb_noc_test_node.sv
// Directed bench for noc_test_node: sender timing/stalls, reset mid-packet, receive checks, loopback.
module tb_noc_test_node;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_ready;
    logic        r_valid;
    logic [31:0] r_flit;
    logic        r_hdr;
    logic        r_tail;
    logic        rready;
    logic        s_valid;
    logic [31:0] s_flit;
    logic        s_hdr;
    logic        s_tail;
    logic [7:0]  rnum;
    logic [7:0]  txnum;
    logic        rerr;

    logic        lp_valid;
    logic        lp_ready;
    logic [31:0] lp_flit;
    logic        lp_hdr;
    logic        lp_tail;
    logic [7:0]  lp_rnum;
    logic [7:0]  lp_txnum;
    logic        lp_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    noc_test_node #(
        .X_ID(0), .Y_ID(0), .DEST_X_ID(1), .DEST_Y_ID(1), .DATA_WIDTH(32),
        .PKT_LEN(3), .NUM_PKTS(8), .START_DELAY(16), .GAP(4)
    ) u_dut (
        .noc_clk          (clk),
        .noc_rst          (rst),
        .receive_valid    (r_valid),
        .receive_ready    (rready),
        .receive_flit     (r_flit),
        .receive_is_header(r_hdr),
        .receive_is_tail  (r_tail),
        .sender_valid     (s_valid),
        .sender_ready     (s_ready),
        .sender_flit      (s_flit),
        .sender_is_header (s_hdr),
        .sender_is_tail   (s_tail),
        .receive_num      (rnum),
        .tx_num           (txnum),
        .rx_error         (rerr)
    );

    // Sender looped straight back into its own receiver.
    noc_test_node #(
        .X_ID(1), .Y_ID(1), .DEST_X_ID(1), .DEST_Y_ID(1), .DATA_WIDTH(32),
        .PKT_LEN(1), .NUM_PKTS(8), .START_DELAY(2), .GAP(0)
    ) u_loop (
        .noc_clk          (clk),
        .noc_rst          (rst),
        .receive_valid    (lp_valid),
        .receive_ready    (lp_ready),
        .receive_flit     (lp_flit),
        .receive_is_header(lp_hdr),
        .receive_is_tail  (lp_tail),
        .sender_valid     (lp_valid),
        .sender_ready     (lp_ready),
        .sender_flit      (lp_flit),
        .sender_is_header (lp_hdr),
        .sender_is_tail   (lp_tail),
        .receive_num      (lp_rnum),
        .tx_num           (lp_txnum),
        .rx_error         (lp_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] hdr_exp(input logic [7:0] s);
        return {16'h1100, s, 8'h03};
    endfunction

    function automatic logic [31:0] body_exp(input logic [7:0] s, input logic [15:0] k);
        return {8'h00, s, k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic rx_flit(input logic [31:0] f, input logic h, input logic t);
        r_valid = 1'b1;
        r_flit  = f;
        r_hdr   = h;
        r_tail  = t;
        tick();
        r_valid = 1'b0;
        r_flit  = '0;
        r_hdr   = 1'b0;
        r_tail  = 1'b0;
    endtask

    initial begin
        logic        ev, eh, et;
        logic [7:0]  etx;
        logic [31:0] ef;
        logic [34:0] held;
        logic        prev_stall;
        int          rel, p, ph, idx;

        rst     = 1'b1;
        s_ready = 1'b1;
        r_valid = 1'b0;
        r_flit  = '0;
        r_hdr   = 1'b0;
        r_tail  = 1'b0;

        // Reset values, then full-rate sending with cycle-exact expectations.
        tick();
        chk("reset_ctrl", {59'd0, s_valid, s_hdr, s_tail, rready, rerr}, 64'd0);
        chk("reset_flit", {32'd0, s_flit}, 64'd0);
        chk("reset_cnt", {48'd0, rnum, txnum}, 64'd0);
        repeat (9) tick();
        rst = 1'b0;
        for (int c = 0; c < 110; c++) begin
            ev  = 1'b0;
            eh  = 1'b0;
            et  = 1'b0;
            ef  = '0;
            etx = '0;
            if (c >= 17) begin
                rel = c - 17;
                p   = rel / 8;
                ph  = rel % 8;
                if (p < 8 && ph < 4) begin
                    ev = 1'b1;
                    if (ph == 0) begin
                        eh = 1'b1;
                        ef = hdr_exp(8'(p));
                    end else begin
                        ef = body_exp(8'(p), 16'(ph - 1));
                        et = (ph == 3);
                    end
                end
            end
            if (c >= 21) etx = 8'((((c - 21) / 8 + 1) > 8) ? 8 : ((c - 21) / 8 + 1));
            chk($sformatf("tx_cycle%0d", c),
                {21'd0, s_valid, s_hdr, s_tail, txnum, s_flit},
                {21'd0, ev, eh, et, etx, ef});
            if (c == 5) chk("rready_on", {63'd0, rready}, 64'd1);
            tick();
        end
        chk("idle_rnum", {56'd0, rnum}, 64'd0);
        chk("loop_rnum", {56'd0, lp_rnum}, 64'd8);
        chk("loop_txnum", {56'd0, lp_txnum}, 64'd8);
        chk("loop_err_valid", {62'd0, lp_err, lp_valid}, 64'd0);

        // Random sender stalls: fields hold while stalled, stream arrives intact and in order.
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        idx        = 0;
        prev_stall = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < 3000 && idx < 32; cyc++) begin
            if (prev_stall) chk("stall_hold", {29'd0, s_valid, s_hdr, s_tail, s_flit}, {29'd0, held});
            s_ready = 1'($urandom_range(0, 1));
            if (s_valid && s_ready) begin
                p  = idx / 4;
                ph = idx % 4;
                if (ph == 0) ef = hdr_exp(8'(p));
                else ef = body_exp(8'(p), 16'(ph - 1));
                chk($sformatf("stream%0d", idx), {30'd0, s_hdr, s_tail, s_flit},
                    {30'd0, (ph == 0), (ph == 3), ef});
                idx++;
            end
            prev_stall = s_valid && !s_ready;
            held       = {s_valid, s_hdr, s_tail, s_flit};
            tick();
        end
        chk("stream_count", 64'(idx), 64'd32);
        s_ready = 1'b1;
        tick();
        chk("stall_done", {55'd0, s_valid, txnum}, {55'd0, 1'b0, 8'd8});

        // Reset during the body of packet 3 abandons it and restarts from seq 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (42) tick();
        chk("pkt3_body0", {29'd0, s_valid, s_hdr, s_tail, s_flit},
            {29'd0, 1'b1, 1'b0, 1'b0, body_exp(8'd3, 16'd0)});
        chk("pkt3_txnum", {56'd0, txnum}, 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outs", {12'd0, s_valid, s_hdr, s_tail, s_flit, txnum, rnum, rerr, rready}, 64'd0);
        repeat (17) tick();
        chk("restart_hdr", {22'd0, s_valid, s_hdr, s_flit, txnum},
            {22'd0, 1'b1, 1'b1, hdr_exp(8'd0), 8'd0});

        // Receive checks on node (0,0).
        pulse_reset();
        chk("rx_ready", {63'd0, rready}, 64'd1);
        rx_flit(32'h0000_0003, 1'b1, 1'b0);
        chk("rx_good_hdr", {55'd0, rerr, rnum}, {55'd0, 1'b0, 8'd0});
        rx_flit(32'h1100_0000, 1'b0, 1'b0);
        rx_flit(32'h1100_0001, 1'b0, 1'b1);
        chk("rx_good_pkt", {55'd0, rerr, rnum}, {55'd0, 1'b0, 8'd1});
        rx_flit(32'h0000_0000, 1'b1, 1'b1);
        chk("rx_one_flit", {55'd0, rerr, rnum}, {55'd0, 1'b0, 8'd2});
        rx_flit(32'h0100_0003, 1'b1, 1'b0);
        chk("rx_bad_desty", {63'd0, rerr}, 64'd1);
        rx_flit(32'h0000_0000, 1'b0, 1'b1);
        chk("rx_err_count", {55'd0, rerr, rnum}, {55'd0, 1'b1, 8'd3});
        repeat (3) tick();
        chk("rx_err_sticky", {63'd0, rerr}, 64'd1);

        pulse_reset();
        chk("rx_err_cleared", {63'd0, rerr}, 64'd0);
        rx_flit(32'h0000_0000, 1'b0, 1'b0);
        chk("rx_orphan_body", {63'd0, rerr}, 64'd1);

        pulse_reset();
        rx_flit(32'h0000_0003, 1'b1, 1'b0);
        chk("rx_hdr_first", {63'd0, rerr}, 64'd0);
        rx_flit(32'h0000_0003, 1'b1, 1'b0);
        chk("rx_hdr_twice", {63'd0, rerr}, 64'd1);

        pulse_reset();
        rx_flit(32'h1000_0000, 1'b1, 1'b1);
        chk("rx_bad_destx", {55'd0, rerr, rnum}, {55'd0, 1'b1, 8'd1});

        // Back-to-back one-flit packets drive receive_num into saturation.
        pulse_reset();
        r_valid = 1'b1;
        r_hdr   = 1'b1;
        r_tail  = 1'b1;
        r_flit  = '0;
        repeat (254) tick();
        chk("rx_count254", {56'd0, rnum}, 64'd254);
        repeat (2) tick();
        chk("rx_saturate", {55'd0, rerr, rnum}, {55'd0, 1'b0, 8'd255});
        r_valid = 1'b0;
        r_hdr   = 1'b0;
        r_tail  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
